// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for the 16:1 inverting strobed selector: visits every enabled
// channel in ascending order, samples after a settle time, and reports a 16-bit snapshot.
module mux16_scan_ctrl #(
    parameter int SETTLE = 1,
    parameter int NCH    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [NCH-1:0] ch_mask,
    input  logic           mux_out,
    output logic [3:0]     sel,
    output logic           mux_dis,
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]     state_r, state_s;
    logic [3:0]     sel_r, sel_s;
    logic [3:0]     cnt_r, cnt_s;
    logic [NCH-1:0] mask_r, mask_s;
    logic [NCH-1:0] shadow_r, shadow_s;
    logic [NCH-1:0] data_r, data_s;
    logic           mux_dis_r, mux_dis_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic [3:0]     first_sel_s;
    logic [3:0]     next_sel_s;
    logic           has_next_s;

    // Lowest set bit of the incoming mask, and next set latched bit above sel.
    always_comb begin
        first_sel_s = 4'd0;
        next_sel_s  = sel_r;
        has_next_s  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            first_sel_s = ch_mask[i] ? 4'(i) : first_sel_s;
            if (mask_r[i] && (i > int'(sel_r))) begin
                next_sel_s = 4'(i);
                has_next_s = 1'b1;
            end else begin
                next_sel_s = next_sel_s;
                has_next_s = has_next_s;
            end
        end
    end

    // Next-state and datapath; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        cnt_s    = cnt_r;
        mask_s   = mask_r;
        shadow_s = shadow_r;
        data_s   = data_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    shadow_s = {NCH{1'b0}};
                    if (ch_mask != {NCH{1'b0}}) begin
                        mask_s  = ch_mask;
                        sel_s   = first_sel_s;
                        cnt_s   = CNT_LOAD;
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    shadow_s[sel_r] = ~mux_out;
                    if (has_next_s) begin
                        sel_s   = next_sel_s;
                        cnt_s   = CNT_LOAD;
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_DONE) begin
            data_s = shadow_s;
        end else begin
            data_s = data_s;
        end
        mux_dis_s = (state_s == ST_IDLE) || (state_s == ST_DONE);
        busy_s    = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
        done_s    = (state_s == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sel_r     <= 4'd0;
            cnt_r     <= 4'd0;
            mask_r    <= {NCH{1'b0}};
            shadow_r  <= {NCH{1'b0}};
            data_r    <= {NCH{1'b0}};
            mux_dis_r <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            sel_r     <= sel_s;
            cnt_r     <= cnt_s;
            mask_r    <= mask_s;
            shadow_r  <= shadow_s;
            data_r    <= data_s;
            mux_dis_r <= mux_dis_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign sel     = sel_r;
    assign mux_dis = mux_dis_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign data    = data_r;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl: table of scans on a SETTLE=1 instance,
// a full scan on a SETTLE=2 instance, and hand-written abort/reset/busy sequences.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2, abort;
    logic [15:0] ch_mask;
    logic [15:0] pat1, pat2;
    logic        mux_out1, mux_out2;
    logic [3:0]  sel1, sel2;
    logic        mux_dis1, mux_dis2, busy1, busy2, done1, done2;
    logic [15:0] data1, data2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Selector model: inverting, forced high while disabled.
    assign mux_out1 = mux_dis1 ? 1'b1 : ~pat1[sel1];
    assign mux_out2 = mux_dis2 ? 1'b1 : ~pat2[sel2];

    mux16_scan_ctrl #(.SETTLE(1), .NCH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .ch_mask(ch_mask),
        .mux_out(mux_out1), .sel(sel1), .mux_dis(mux_dis1), .busy(busy1),
        .done(done1), .data(data1));

    mux16_scan_ctrl #(.SETTLE(2), .NCH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .ch_mask(ch_mask),
        .mux_out(mux_out2), .sel(sel2), .mux_dis(mux_dis2), .busy(busy2),
        .done(done2), .data(data2));

    typedef struct {
        logic [15:0] mask;
        logic [15:0] pat;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_scan(input bit use2, input logic [15:0] m, input logic [15:0] p,
                            input logic [15:0] exp_d, input int exp_lat, input int settle);
        int          lat = -1;
        int          en_cycles = 0;
        int          prev = -1;
        logic [15:0] visited = 16'h0000;
        bit          asc = 1'b1;
        bit          busy_seen = 1'b0;
        logic [3:0]  s;
        @(negedge clk);
        ch_mask = m;
        if (use2) begin pat2 = p; start2 = 1'b1; end
        else      begin pat1 = p; start1 = 1'b1; end
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            s = use2 ? sel2 : sel1;
            busy_seen = busy_seen | (use2 ? busy2 : busy1);
            if (!(use2 ? mux_dis2 : mux_dis1)) begin
                en_cycles++;
                visited = visited | (16'h0001 << s);
                if (int'(s) < prev) asc = 1'b0;
                prev = int'(s);
            end
            if (use2 ? done2 : done1) begin
                lat = c;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("data", 32'(use2 ? data2 : data1), 32'(exp_d));
        chk("visited", 32'(visited), 32'(m));
        chk("ascending", 32'(asc), 32'd1);
        chk("enabled_cycles", 32'(en_cycles), 32'($countones(m) * (settle + 1)));
        if (m == 16'h0000) chk("busy_never", 32'(busy_seen), 32'd0);
        @(negedge clk);
        chk("done_one_pulse", 32'(use2 ? done2 : done1), 32'd0);
        chk("idle_mux_dis", 32'(use2 ? mux_dis2 : mux_dis1), 32'd1);
    endtask

    initial begin
        int dn;
        bit hit;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0;
        ch_mask = 16'h0000; pat1 = 16'hFFFF; pat2 = 16'hFFFF;

        vecs[0] = '{16'h0001, 16'hFFFF, 16'h0001, 3};
        vecs[1] = '{16'h8101, 16'hFFFF, 16'h8101, 7};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 1};
        vecs[3] = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 33};
        vecs[4] = '{16'h00F0, 16'h1234, 16'h0030, 9};
        vecs[5] = '{16'h8000, 16'h8000, 16'h8000, 3};
        vecs[6] = '{16'h0F0F, 16'h5A5A, 16'h0A0A, 17};
        vecs[7] = '{16'h1234, 16'hFFFF, 16'h1234, 11};

        #12;
        chk("rst_sel", 32'(sel1), 32'd0);
        chk("rst_mux_dis", 32'(mux_dis1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_data", 32'(data1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_scan(1'b0, vecs[i].mask, vecs[i].pat, vecs[i].exp_data, vecs[i].exp_lat, 1);

        run_scan(1'b1, 16'hFFFF, 16'hA5C3, 16'hA5C3, 49, 2);

        // Abort during the third channel; previous snapshot 0x1234 must survive.
        @(negedge clk);
        ch_mask = 16'hFFFF; pat1 = 16'hFFFF; start1 = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (sel1 == 4'd2 && !mux_dis1) begin hit = 1'b1; break; end
        end
        chk("abort_reach_ch2", 32'(hit), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_mux_dis", 32'(mux_dis1), 32'd1);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_data", 32'(data1), 32'h1234);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done1) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);

        // Start and abort together in IDLE: start ignored.
        ch_mask = 16'h0001; start1 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy1), 32'd0);
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done1) dn++;
        end
        chk("start_abort_no_done", 32'(dn), 32'd0);

        // Start re-pulsed while busy with a different mask: ignored.
        ch_mask = 16'h0003; pat1 = 16'hFFFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        ch_mask = 16'hFFFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done1) dn++;
            @(negedge clk);
        end
        chk("busy_start_dones", 32'(dn), 32'd1);
        chk("busy_start_data", 32'(data1), 32'h0003);

        // Asynchronous reset mid-SETTLE, checked before the next clock edge.
        ch_mask = 16'hFFFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(sel1), 32'd0);
        chk("mid_rst_mux_dis", 32'(mux_dis1), 32'd1);
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        chk("mid_rst_done", 32'(done1), 32'd0);
        chk("mid_rst_data", 32'(data1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
